// File: rtl/uc_multiciclo.sv
// Multicycle control unit for ld/sd/add/sub/addi driving register file, ULA and data memory.
// Optional build macro X0_PROTECT_EN: suppresses register writes that target x0.
module uc_multiciclo #(
  parameter int DATA_WIDTH = 64,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  output logic [4:0]            Ra,
  output logic [4:0]            Rb,
  output logic [4:0]            Rw,
  output logic                  WeR,
  output logic                  WeM,
  output logic [DATA_WIDTH-1:0] constante,
  output logic                  soma_ou_subtrai,
  output logic                  subtraindo,
  output logic [1:0]            escolhe_entrada1,
  output logic [1:0]            escolhe_entrada2,
  output logic                  sel_dinR,
  output logic                  done,
  output logic                  erro
);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_instr;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        w_wer, w_wem, w_done, w_erro;

  logic [6:0]  w_op, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [11:0] w_imm_i, w_imm_s;
  logic        w_is_ld, w_is_sd, w_is_r, w_is_addi, w_legal;

  function automatic logic [DATA_WIDTH-1:0] sext12(input logic [11:0] v);
    return {{(DATA_WIDTH-12){v[11]}}, v};
  endfunction

  assign w_op    = r_instr[6:0];
  assign w_rd    = r_instr[11:7];
  assign w_f3    = r_instr[14:12];
  assign w_rs1   = r_instr[19:15];
  assign w_rs2   = r_instr[24:20];
  assign w_f7    = r_instr[31:25];
  assign w_imm_i = r_instr[31:20];
  assign w_imm_s = {r_instr[31:25], r_instr[11:7]};

  assign w_is_ld   = (w_op == 7'b0000011) && (w_f3 == 3'b011);
  assign w_is_sd   = (w_op == 7'b0100011) && (w_f3 == 3'b011);
  assign w_is_r    = (w_op == 7'b0110011) && (w_f3 == 3'b000) &&
                     ((w_f7 == 7'b0000000) || (w_f7 == 7'b0100000));
  assign w_is_addi = (w_op == 7'b0010011) && (w_f3 == 3'b000);
  assign w_legal   = w_is_ld | w_is_sd | w_is_r | w_is_addi;

  // Datapath controls follow the latched word, so they hold from DECODE to the next DECODE.
  always_comb begin
    Ra               = '0;
    Rb               = '0;
    Rw               = '0;
    constante        = '0;
    soma_ou_subtrai  = 1'b0;
    subtraindo       = 1'b0;
    escolhe_entrada1 = 2'd0;
    escolhe_entrada2 = 2'd0;
    sel_dinR         = 1'b0;
    if (w_is_ld) begin
      Rb               = w_rs1;
      Rw               = w_rd;
      constante        = sext12(w_imm_i);
      escolhe_entrada2 = 2'd2;
      sel_dinR         = 1'b1;
      soma_ou_subtrai  = 1'b1;
    end else if (w_is_sd) begin
      Rb               = w_rs1;
      Ra               = w_rs2;
      constante        = sext12(w_imm_s);
      escolhe_entrada2 = 2'd2;
      soma_ou_subtrai  = 1'b1;
    end else if (w_is_r) begin
      Ra               = w_rs1;
      Rb               = w_rs2;
      Rw               = w_rd;
      escolhe_entrada1 = 2'd1;
      subtraindo       = w_f7[5];
      soma_ou_subtrai  = 1'b1;
    end else if (w_is_addi) begin
      Rb               = w_rs1;
      Rw               = w_rd;
      constante        = sext12(w_imm_i);
      escolhe_entrada2 = 2'd2;
      soma_ou_subtrai  = 1'b1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_cnt_nxt   = r_cnt;
    instr_ready = 1'b0;
    w_wer       = 1'b0;
    w_wem       = 1'b0;
    w_done      = 1'b0;
    w_erro      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_legal) w_next = S_EXEC;
        else begin
          w_erro = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_EXEC: begin
        w_cnt_nxt = '0;
        w_next    = (w_is_ld || w_is_sd) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (w_is_sd) begin
          w_wem  = 1'b1;
          w_done = 1'b1;
          w_next = S_IDLE;
        end else if (r_cnt == 4'(MEM_LAT - 1)) begin
          w_next = S_WB;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_WB: begin
`ifdef X0_PROTECT_EN
        w_wer  = (w_rd != 5'd0);
`else
        w_wer  = 1'b1;
`endif
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes are masked during reset so an interrupted operation never commits.
  assign WeR  = w_wer  & ~reset;
  assign WeM  = w_wem  & ~reset;
  assign done = w_done & ~reset;
  assign erro = w_erro & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_instr <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (r_state == S_IDLE && instr_valid) r_instr <= instr;
    end
  end

endmodule
